// File: rtl/axi_burst_memory.sv
// Purpose: AXI slave word memory backing the core's I/D-cache line fills and D-cache write-backs.
// Latency: first R beat READ_LATENCY cycles after the AR handshake, then one beat per cycle; writes commit on the W handshake.
// Backpressure: R beats are held stable while RREADY is low; B is held until BREADY; each engine takes one transaction at a time.
// Ports: clk/rst (sync, active-high); AW/W/B write channels; AR/R read channels; proto_err sticky WLAST/WID violation flag.
module axi_burst_memory #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 14,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // write address
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [3:0]            AWID,
    input  logic [3:0]            AWLEN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    // write data
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic                  WLAST,
    input  logic [3:0]            WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    // write response
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [3:0]            BID,
    // read address
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [3:0]            ARID,
    input  logic [3:0]            ARLEN,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    // read data
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  RLAST,
    output logic [3:0]            RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  proto_err
);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Upper address bits are deliberately ignored: the index wraps inside the array.
    wire unused_addr_bits = ^{AWADDR[ADDR_WIDTH-1:DEPTH_LOG2], ARADDR[ADDR_WIDTH-1:DEPTH_LOG2]};

    // ---------------- read engine ----------------
    r_state_t              r_state, r_next;
    logic [3:0]            r_id, r_len, r_beat;
    logic [DEPTH_LOG2-1:0] r_addr, r_addr_nxt;
    logic [CW-1:0]         r_cnt;

    assign ARREADY    = (r_state == R_IDLE);
    assign r_addr_nxt = r_addr + 1'b1;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ARVALID)         r_next = R_WAIT;
            R_WAIT:  if (r_cnt == '0)     r_next = R_BURST;
            R_BURST: if (RREADY && RLAST) r_next = R_IDLE;
            default:                      r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
        end else begin
            r_state <= r_next;
            case (r_state)
                R_IDLE: if (ARVALID) begin
                    r_id   <= ARID;
                    r_len  <= ARLEN;
                    r_addr <= ARADDR[DEPTH_LOG2-1:0];
                    r_beat <= '0;
                    r_cnt  <= CW'(READ_LATENCY - 1);
                end
                R_WAIT: begin
                    if (r_cnt == '0) begin
                        RDATA  <= mem[r_addr];
                        RID    <= r_id;
                        RLAST  <= (r_len == 4'd0);
                        RVALID <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                R_BURST: if (RREADY) begin
                    if (RLAST) begin
                        RVALID <= 1'b0;
                        RLAST  <= 1'b0;
                    end else begin
                        // Fetch the next word on the handshake edge so beats stream back to back.
                        r_beat <= r_beat + 4'd1;
                        r_addr <= r_addr_nxt;
                        RDATA  <= mem[r_addr_nxt];
                        RLAST  <= ((r_beat + 4'd1) == r_len);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write engine ----------------
    w_state_t              w_state, w_next;
    logic [3:0]            w_id, w_len, w_beat;
    logic [DEPTH_LOG2-1:0] w_addr;
    logic                  w_fire, w_final;

    assign AWREADY = (w_state == W_IDLE);
    assign WREADY  = (w_state == W_DATA);
    assign BVALID  = (w_state == W_RESP);
    assign BID     = w_id;
    assign w_fire  = WVALID && WREADY;
    assign w_final = (w_beat == w_len);

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (AWVALID)           w_next = W_DATA;
            W_DATA:  if (w_fire && w_final) w_next = W_RESP;   // beat count alone ends the burst
            W_RESP:  if (BREADY)            w_next = W_IDLE;
            default:                        w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            w_id      <= '0;
            w_len     <= '0;
            w_beat    <= '0;
            w_addr    <= '0;
            proto_err <= 1'b0;
        end else begin
            w_state <= w_next;
            if (AWVALID && AWREADY) begin
                w_id   <= AWID;
                w_len  <= AWLEN;
                w_addr <= AWADDR[DEPTH_LOG2-1:0];
                w_beat <= '0;
            end
            if (w_fire) begin
                w_addr <= w_addr + 1'b1;
                w_beat <= w_beat + 4'd1;
                if ((WLAST != w_final) || (WID != w_id))
                    proto_err <= 1'b1;
            end
        end
    end

    // Storage has no reset; a same-edge read in the read engine sees the old word.
    always_ff @(posedge clk) begin
        if (w_fire && !rst)
            mem[w_addr] <= WDATA;
    end
endmodule
